// File: rtl/baccarat_dealer_pkg.sv
// Shared types, card-code constants and scoring helpers for the baccarat dealer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEAL_P1,
    ST_DEAL_B1,
    ST_DEAL_P2,
    ST_DEAL_B2,
    ST_EVAL,
    ST_DEAL_P3,
    ST_EVAL_B,
    ST_DEAL_B3,
    ST_DONE
  } state_e;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_MIN  = 4'd1;
  localparam logic [3:0] CARD_MAX  = 4'd13;
  localparam logic [3:0] CARD_NINE = 4'd9;

  function automatic logic card_legal(input logic [3:0] code);
    return (code >= CARD_MIN) && (code <= CARD_MAX);
  endfunction

  // Ten and the court cards count as zero; an empty slot also counts as zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if ((code >= CARD_MIN) && (code <= CARD_NINE)) begin
      return code;
    end
    return 4'd0;
  endfunction

  // Banker third-card tableau once the player has drawn a card of value v.
  function automatic logic banker_draws(input logic [3:0] bscore,
                                        input logic [3:0] v);
    logic draw;
    draw = 1'b0;
    case (bscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_dealer_if.sv
// Card-shoe handshake and hand-result bundle between a table controller and the dealer.
interface baccarat_dealer_if;
  logic       start;
  logic [3:0] card_in;
  logic       card_valid;
  logic       card_ready;
  logic [3:0] pcard1;
  logic [3:0] pcard2;
  logic [3:0] pcard3;
  logic [3:0] bcard1;
  logic [3:0] bcard2;
  logic [3:0] bcard3;
  logic [3:0] pscore;
  logic [3:0] bscore;
  logic       done;
  logic       player_win;
  logic       banker_win;

  modport master (
    output start, card_in, card_valid,
    input  card_ready, pcard1, pcard2, pcard3, bcard1, bcard2, bcard3,
    input  pscore, bscore, done, player_win, banker_win
  );

  modport slave (
    input  start, card_in, card_valid,
    output card_ready, pcard1, pcard2, pcard3, bcard1, bcard2, bcard3,
    output pscore, bscore, done, player_win, banker_win
  );
endinterface

// File: rtl/baccarat_dealer_scorehand.sv
// Combinational hand total: sum of three card values modulo 10.
module scorehand
  import baccarat_pkg::*;
(
  input  logic [3:0] card1_i,
  input  logic [3:0] card2_i,
  input  logic [3:0] card3_i,
  output logic [3:0] total_o
);

  logic [4:0] sum;
  logic [4:0] reduced;

  always_comb begin
    sum = {1'b0, card_value(card1_i)} + {1'b0, card_value(card2_i)}
        + {1'b0, card_value(card3_i)};
    // Sum never exceeds 27, so at most two tens need removing.
    if (sum >= 5'd20) begin
      reduced = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      reduced = sum - 5'd10;
    end else begin
      reduced = sum;
    end
    total_o = reduced[3:0];
  end

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat dealer: deals P1,B1,P2,B2, applies third-card rules and reports the winner.
module baccarat_dealer
  import baccarat_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  baccarat_dealer_if.slave   bus
);

  state_e     state_q, state_d;
  logic [3:0] pcard_q [3];
  logic [3:0] pcard_d [3];
  logic [3:0] bcard_q [3];
  logic [3:0] bcard_d [3];

  logic       card_ready;
  logic       accept;
  logic [3:0] pscore;
  logic [3:0] bscore;
  logic       natural;

  scorehand u_player_score (
    .card1_i (pcard_q[0]),
    .card2_i (pcard_q[1]),
    .card3_i (pcard_q[2]),
    .total_o (pscore)
  );

  scorehand u_banker_score (
    .card1_i (bcard_q[0]),
    .card2_i (bcard_q[1]),
    .card3_i (bcard_q[2]),
    .total_o (bscore)
  );

  always_comb begin
    card_ready = (state_q == ST_DEAL_P1) || (state_q == ST_DEAL_B1) ||
                 (state_q == ST_DEAL_P2) || (state_q == ST_DEAL_B2) ||
                 (state_q == ST_DEAL_P3) || (state_q == ST_DEAL_B3);
    accept     = bus.card_valid && card_ready && card_legal(bus.card_in);
    natural    = (pscore >= 4'd8) || (bscore >= 4'd8);
  end

  always_comb begin
    state_d = state_q;
    pcard_d = pcard_q;
    bcard_d = bcard_q;
    case (state_q)
      // card_ready is low here, so a coincident card is never taken.
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          pcard_d = '{default: CARD_NONE};
          bcard_d = '{default: CARD_NONE};
          state_d = ST_DEAL_P1;
        end
      end
      ST_DEAL_P1: begin
        if (accept) begin
          pcard_d[0] = bus.card_in;
          state_d    = ST_DEAL_B1;
        end
      end
      ST_DEAL_B1: begin
        if (accept) begin
          bcard_d[0] = bus.card_in;
          state_d    = ST_DEAL_P2;
        end
      end
      ST_DEAL_P2: begin
        if (accept) begin
          pcard_d[1] = bus.card_in;
          state_d    = ST_DEAL_B2;
        end
      end
      ST_DEAL_B2: begin
        if (accept) begin
          bcard_d[1] = bus.card_in;
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (natural) begin
          state_d = ST_DONE;
        end else if (pscore <= 4'd5) begin
          state_d = ST_DEAL_P3;
        end else if (bscore <= 4'd5) begin
          state_d = ST_DEAL_B3;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DEAL_P3: begin
        if (accept) begin
          pcard_d[2] = bus.card_in;
          state_d    = ST_EVAL_B;
        end
      end
      ST_EVAL_B: begin
        if (banker_draws(bscore, card_value(pcard_q[2]))) begin
          state_d = ST_DEAL_B3;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DEAL_B3: begin
        if (accept) begin
          bcard_d[2] = bus.card_in;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int unsigned i = 0; i < 3; i++) begin
        pcard_q[i] <= CARD_NONE;
        bcard_q[i] <= CARD_NONE;
      end
    end else begin
      state_q <= state_d;
      pcard_q <= pcard_d;
      bcard_q <= bcard_d;
    end
  end

  assign bus.card_ready = card_ready;
  assign bus.pcard1     = pcard_q[0];
  assign bus.pcard2     = pcard_q[1];
  assign bus.pcard3     = pcard_q[2];
  assign bus.bcard1     = bcard_q[0];
  assign bus.bcard2     = bcard_q[1];
  assign bus.bcard3     = bcard_q[2];
  assign bus.pscore     = pscore;
  assign bus.bscore     = bscore;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.player_win = (state_q == ST_DONE) && (pscore >= bscore);
  assign bus.banker_win = (state_q == ST_DONE) && (bscore >= pscore);

endmodule

// File: tb/tb_baccarat_dealer.sv
// Bench for baccarat_dealer: rules-level hand model checked every cycle plus literal hand results.
module tb_baccarat_dealer;

  logic clk;
  logic reset;

  baccarat_dealer_if bus ();

  baccarat_dealer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Rules-level model: cards held per hand, plus whether an evaluation pause is pending.
  int mp [3];
  int mb [3];
  int m_n;
  bit m_active;
  bit m_done;
  bit m_gap;
  int m_acc_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cval(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int tot(input int a, input int b, input int c);
    return (cval(a) + cval(b) + cval(c)) % 10;
  endfunction

  function automatic bit banker_rule(input int bs, input int v);
    if (bs <= 2) return 1'b1;
    if (bs == 3) return v != 8;
    if (bs == 4) return v >= 2 && v <= 7;
    if (bs == 5) return v >= 4 && v <= 7;
    if (bs == 6) return v == 6 || v == 7;
    return 1'b0;
  endfunction

  // Slot the next card belongs to (0-2 player, 3-5 banker), or -1 if the hand is complete.
  function automatic int next_slot();
    int ps, bs;
    if (m_n == 0) return 0;
    if (m_n == 1) return 3;
    if (m_n == 2) return 1;
    if (m_n == 3) return 4;
    ps = tot(mp[0], mp[1], mp[2]);
    bs = tot(mb[0], mb[1], mb[2]);
    if (mb[2] != 0) return -1;
    if (mp[2] != 0) return banker_rule(bs, cval(mp[2])) ? 5 : -1;
    if (ps >= 8 || bs >= 8) return -1;
    if (ps <= 5) return 2;
    if (bs <= 5) return 5;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0;
      mb[i] = 0;
    end
    m_n   = 0;
    m_gap = 1'b0;
    m_done = 1'b0;
  endtask

  initial begin
    int s;
    model_clear();
    m_active = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        model_clear();
        m_active = 1'b0;
      end else if (bus.start && (!m_active || m_done)) begin
        model_clear();
        m_active = 1'b1;
      end else if (m_active && !m_done) begin
        if (m_gap) begin
          m_gap = 1'b0;
          if (next_slot() < 0) m_done = 1'b1;
        end else if (bus.card_valid && bus.card_in >= 1 && bus.card_in <= 13) begin
          s = next_slot();
          if (s >= 0) begin
            if (s < 3) mp[s] = int'(bus.card_in);
            else       mb[s-3] = int'(bus.card_in);
            m_n++;
            m_acc_cnt++;
            if (s == 5) m_done = 1'b1;
            else if (s == 4 || s == 2) m_gap = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int eps, ebs, ed;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        eps = tot(mp[0], mp[1], mp[2]);
        ebs = tot(mb[0], mb[1], mb[2]);
        ed  = m_done ? 1 : 0;
        chk("pcard1", int'(bus.pcard1), mp[0]);
        chk("pcard2", int'(bus.pcard2), mp[1]);
        chk("pcard3", int'(bus.pcard3), mp[2]);
        chk("bcard1", int'(bus.bcard1), mb[0]);
        chk("bcard2", int'(bus.bcard2), mb[1]);
        chk("bcard3", int'(bus.bcard3), mb[2]);
        chk("pscore", int'(bus.pscore), eps);
        chk("bscore", int'(bus.bscore), ebs);
        chk("done", int'(bus.done), ed);
        chk("card_ready", int'(bus.card_ready),
            (m_active && !m_done && !m_gap) ? 1 : 0);
        chk("player_win", int'(bus.player_win), (m_done && eps >= ebs) ? 1 : 0);
        chk("banker_win", int'(bus.banker_win), (m_done && ebs >= eps) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_hand();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Present a card and hold it until the model records its acceptance (bounded).
  task automatic feed(input int c);
    int prev;
    prev = m_acc_cnt;
    bus.card_in    = 4'(c);
    bus.card_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m_acc_cnt != prev) break;
    end
    if (m_acc_cnt == prev) begin
      n_checks++;
      n_errors++;
      $display("FAIL feed_timeout: card %0d never accepted", c);
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30 && !m_done; k++) tick();
    if (!m_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: hand never completed");
    end
    tick();
  endtask

  task automatic chk_hand(input string tag, input int p3, input int b3, input int ps,
                          input int bs, input int pw, input int bw);
    chk({tag, "_done"}, int'(bus.done), 1);
    chk({tag, "_pcard3"}, int'(bus.pcard3), p3);
    chk({tag, "_bcard3"}, int'(bus.bcard3), b3);
    chk({tag, "_pscore"}, int'(bus.pscore), ps);
    chk({tag, "_bscore"}, int'(bus.bscore), bs);
    chk({tag, "_pwin"}, int'(bus.player_win), pw);
    chk({tag, "_bwin"}, int'(bus.banker_win), bw);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.card_in    = 4'd0;
    bus.card_valid = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ready", int'(bus.card_ready), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pwin", int'(bus.player_win), 0);
    reset = 1'b0;
    tick();

    // Natural: P=8, B=6; done exactly one cycle after the fourth card.
    start_hand();
    feed(8); feed(1); feed(13); feed(5);
    chk("nat_done_early", int'(bus.done), 0);
    tick();
    bus.card_valid = 1'b0;
    chk_hand("nat", 0, 0, 8, 6, 1, 0);
    repeat (3) tick();
    chk("nat_hold_pscore", int'(bus.pscore), 8);

    // Player draws 5, banker on 6 stands.
    start_hand();
    feed(2); feed(3); feed(1); feed(3); feed(5);
    bus.card_valid = 1'b0;
    wait_done();
    chk_hand("pdraw", 5, 0, 8, 6, 1, 0);

    // Banker on 3 stands against a player third card of 8.
    start_hand();
    feed(2); feed(3); feed(1); feed(13); feed(8);
    bus.card_valid = 1'b0;
    wait_done();
    chk_hand("b3exc", 8, 0, 1, 3, 0, 1);

    // Full six-card hand, player wins.
    start_hand();
    feed(4); feed(2); feed(1); feed(3); feed(4); feed(9);
    bus.card_valid = 1'b0;
    wait_done();
    chk_hand("full", 4, 9, 9, 4, 1, 0);

    // Full six-card hand ending in a tie.
    start_hand();
    feed(3); feed(2); feed(2); feed(3); feed(6); feed(6);
    bus.card_valid = 1'b0;
    wait_done();
    chk_hand("tie", 6, 6, 1, 1, 1, 1);

    // Player stands on 7, banker on 4 draws a 5.
    start_hand();
    feed(3); feed(2); feed(4); feed(2); feed(5);
    bus.card_valid = 1'b0;
    wait_done();
    chk_hand("pstand", 0, 5, 7, 9, 0, 1);

    // Robustness: illegal codes, valid dropped, start mid-deal, reset in DEAL_B2.
    start_hand();
    feed(9);
    bus.card_in = 4'd0;  tick(); tick();
    bus.card_in = 4'd14; tick(); tick();
    bus.card_in = 4'd15; tick();
    chk("illegal_bcard1", int'(bus.bcard1), 0);
    chk("illegal_ready", int'(bus.card_ready), 1);
    bus.card_valid = 1'b0;
    repeat (3) tick();
    chk("novalid_pcard1", int'(bus.pcard1), 9);
    feed(7);
    bus.card_valid = 1'b0;
    start_hand();
    chk("midstart_pcard1", int'(bus.pcard1), 9);
    chk("midstart_bcard1", int'(bus.bcard1), 7);
    feed(6);
    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.card_in    = 4'd4;
    bus.card_valid = 1'b1;
    tick();
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.card_valid = 1'b0;
    chk("midrst_pcard1", int'(bus.pcard1), 0);
    chk("midrst_bcard2", int'(bus.bcard2), 0);
    chk("midrst_ready", int'(bus.card_ready), 0);
    chk("midrst_done", int'(bus.done), 0);
    tick();

    // Natural with a ten, then start and a card together in DONE.
    start_hand();
    feed(9); feed(2); feed(10); feed(3);
    bus.card_valid = 1'b0;
    wait_done();
    chk_hand("nat2", 0, 0, 9, 5, 1, 0);
    bus.start      = 1'b1;
    bus.card_in    = 4'd7;
    bus.card_valid = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.card_valid = 1'b0;
    chk("restart_pcard1", int'(bus.pcard1), 0);
    chk("restart_ready", int'(bus.card_ready), 1);
    chk("restart_done", int'(bus.done), 0);

    // Reset beats start in the same cycle.
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rstprio_ready", int'(bus.card_ready), 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
